// File: rtl/spi_cmd_frame_slave.sv
// Oversampled mode-0 SPI slave: opcode+payload frames become write/command strobes, plus feedback readback.
// Define SPI_CRC8_EN to require a trailing CRC-8 byte (poly 0x07) on write frames.
module spi_cmd_frame_slave #(
    parameter int unsigned DATA_BYTES  = 2,
    parameter int unsigned FB_BYTES    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 5000,
    parameter logic [7:0]  RD_OPCODE   = 8'hAB
) (
    input  logic                    clk_in,
    input  logic                    sys_rst,
    input  logic                    sclk,
    input  logic                    cs_n,
    input  logic                    mosi,
    output logic                    miso,
    input  logic [FB_BYTES*8-1:0]   fb_data,
    output logic                    wr_valid,
    output logic [4:0]              wr_addr,
    output logic [DATA_BYTES*8-1:0] wr_data,
    output logic                    cmd_valid,
    output logic [6:0]              cmd_code,
    output logic                    rd_start,
    output logic                    frame_err,
    output logic                    crc_err,
    output logic                    busy
);

    localparam int unsigned DW = DATA_BYTES * 8;
    localparam int unsigned FW = FB_BYTES * 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned L  = SYNC_STAGES - 1;
    localparam logic [1:0]    PAY_LAST = 2'(DATA_BYTES - 1);
    localparam logic [2:0]    RD_LAST  = 3'(FB_BYTES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_OPCODE  = 2'd0,
        ST_PAYLOAD = 2'd1,
`ifdef SPI_CRC8_EN
        ST_CRC     = 2'd3,
`endif
        ST_READ    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic rise_q, fall_q, mosi_q, cs_q, cs_rise_q;
    logic rise_qq, fall_qq, cs_rise_qq;
    logic [6:0]    sh;
    logic [2:0]    bit_cnt;
    logic [7:0]    byte_q;
    logic          byte_done;
    logic [TW-1:0] to_cnt;
    logic          frame_open, timeout;

    logic [1:0]    pay_cnt;
    logic [4:0]    pay_sh_amt;
    logic [DW-1:0] pay_sh, pay_next;
    logic [4:0]    addr_q;
    logic [2:0]    rd_cnt;
    logic          rd_armed;
    logic [FW-1:0] fb_sh, fb_next;
    logic start_wr, take_byte, wr_fire, cmd_fire, rd_fire, ferr_fire, shift_fb;
`ifdef SPI_CRC8_EN
    logic [7:0] crc_q;
    logic       crc_fire;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction
`endif

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            sclk_s    <= '0;
            cs_s      <= '1;
            mosi_s    <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_q      <= 1'b1;
            cs_rise_q <= 1'b0;
        end else begin
            sclk_s    <= {sclk_s[SYNC_STAGES-2:0], sclk};
            cs_s      <= {cs_s[SYNC_STAGES-2:0], cs_n};
            mosi_s    <= {mosi_s[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s[L];
            cs_d      <= cs_s[L];
            rise_q    <= sclk_s[L] & ~sclk_d;
            fall_q    <= ~sclk_s[L] & sclk_d;
            mosi_q    <= mosi_s[L];
            cs_q      <= cs_s[L];
            cs_rise_q <= cs_s[L] & ~cs_d;
        end
    end

    assign frame_open = (state_q != ST_OPCODE) || (bit_cnt != 3'd0);
    assign timeout    = frame_open && !rise_q && (to_cnt == TO_LAST);

    // Bit assembly runs one cycle ahead of the frame FSM; aborts from the FSM side clear it here.
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            sh         <= '0;
            bit_cnt    <= '0;
            byte_q     <= '0;
            byte_done  <= 1'b0;
            rise_qq    <= 1'b0;
            fall_qq    <= 1'b0;
            cs_rise_qq <= 1'b0;
            to_cnt     <= '0;
        end else begin
            byte_done  <= 1'b0;
            rise_qq    <= rise_q & ~cs_q;
            fall_qq    <= fall_q & ~cs_q;
            cs_rise_qq <= cs_rise_q;
            if (cs_q || timeout) begin
                bit_cnt <= '0;
            end else if (rise_q) begin
                sh      <= {sh[5:0], mosi_q};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_q    <= {sh, mosi_q};
                    byte_done <= 1'b1;
                end
            end
            if (!frame_open || rise_q || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) state_q <= ST_OPCODE;
        else         state_q <= state_d;
    end

    assign pay_sh_amt = {pay_cnt, 3'b000};

    always_comb begin
        state_d   = state_q;
        start_wr  = 1'b0;
        take_byte = 1'b0;
        wr_fire   = 1'b0;
        cmd_fire  = 1'b0;
        rd_fire   = 1'b0;
        ferr_fire = 1'b0;
        shift_fb  = 1'b0;
`ifdef SPI_CRC8_EN
        crc_fire  = 1'b0;
`endif
        if (cs_rise_qq) begin
            state_d   = ST_OPCODE;
            ferr_fire = (state_q != ST_OPCODE);
        end else if (timeout) begin
            state_d   = ST_OPCODE;
            ferr_fire = 1'b1;
        end else begin
            case (state_q)
                ST_OPCODE: if (byte_done) begin
                    if (byte_q[7:5] == 3'b100) begin
                        state_d  = ST_PAYLOAD;
                        start_wr = 1'b1;
                    end else if (byte_q == RD_OPCODE) begin
                        state_d = ST_READ;
                        rd_fire = 1'b1;
                    end else if (!byte_q[7]) begin
                        cmd_fire = 1'b1;
                    end else begin
                        ferr_fire = 1'b1;
                    end
                end
                ST_PAYLOAD: if (byte_done) begin
                    take_byte = 1'b1;
                    if (pay_cnt == PAY_LAST) begin
`ifdef SPI_CRC8_EN
                        state_d = ST_CRC;
`else
                        state_d = ST_OPCODE;
                        wr_fire = 1'b1;
`endif
                    end
                end
`ifdef SPI_CRC8_EN
                ST_CRC: if (byte_done) begin
                    state_d = ST_OPCODE;
                    if (byte_q == crc_q) wr_fire  = 1'b1;
                    else                 crc_fire = 1'b1;
                end
`endif
                ST_READ: begin
                    // The fall closing the opcode byte must not shift; only falls after a read-phase rise do.
                    if (fall_qq && rd_armed) shift_fb = 1'b1;
                    if (byte_done && rd_cnt == RD_LAST) state_d = ST_OPCODE;
                end
                default: state_d = ST_OPCODE;
            endcase
        end

        pay_next = pay_sh;
        if (take_byte)
            pay_next = (pay_sh & ~(DW'(8'hFF) << pay_sh_amt)) | (DW'(byte_q) << pay_sh_amt);

        fb_next = fb_sh;
        if (rd_fire)       fb_next = fb_data;
        else if (shift_fb) fb_next = {fb_sh[FW-2:0], 1'b0};
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            rd_start  <= 1'b0;
            frame_err <= 1'b0;
            miso      <= 1'b0;
            pay_cnt   <= '0;
            pay_sh    <= '0;
            addr_q    <= '0;
            rd_cnt    <= '0;
            rd_armed  <= 1'b0;
            fb_sh     <= '0;
`ifdef SPI_CRC8_EN
            crc_err   <= 1'b0;
            crc_q     <= '0;
`endif
        end else begin
            wr_valid  <= wr_fire;
            cmd_valid <= cmd_fire;
            rd_start  <= rd_fire;
            frame_err <= ferr_fire;
            pay_sh    <= pay_next;
            fb_sh     <= fb_next;
            miso      <= (state_d == ST_READ) && fb_next[FW-1];
            if (cmd_fire) cmd_code <= byte_q[6:0];
            if (start_wr) begin
                addr_q  <= byte_q[4:0];
                pay_cnt <= '0;
            end
            if (take_byte) pay_cnt <= pay_cnt + 2'd1;
            if (wr_fire) begin
                wr_addr <= addr_q;
                wr_data <= pay_next;
            end
            if (rd_fire) begin
                rd_cnt   <= '0;
                rd_armed <= 1'b0;
            end else if (state_q == ST_READ) begin
                if (rise_qq)       rd_armed <= 1'b1;
                else if (shift_fb) rd_armed <= 1'b0;
                if (byte_done)     rd_cnt   <= rd_cnt + 3'd1;
            end
`ifdef SPI_CRC8_EN
            crc_err <= crc_fire;
            if (start_wr)       crc_q <= crc8_byte(8'h00, byte_q);
            else if (take_byte) crc_q <= crc8_byte(crc_q, byte_q);
`endif
        end
    end

`ifndef SPI_CRC8_EN
    assign crc_err = 1'b0;
`endif

    assign busy = (state_q != ST_OPCODE);

endmodule

// File: tb/tb_spi_cmd_frame_slave.sv
// Directed bench for spi_cmd_frame_slave: drives SPI frames bit by bit and checks strobes, data and latencies.
module tb_spi_cmd_frame_slave;

    localparam int unsigned SYNC    = 2;
    localparam int unsigned TO_CYC  = 5000;
    localparam int unsigned HALF    = 8;
    localparam int unsigned STB_LAT = SYNC + 3;

    logic        clk_in = 1'b0;
    logic        sys_rst, sclk, cs_n, mosi;
    logic        miso;
    logic [31:0] fb_data;
    logic        wr_valid, cmd_valid, rd_start, frame_err, crc_err, busy;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [6:0]  cmd_code;

    int tests = 0, fails = 0;
    int cyc = 0;
    int wr_cnt = 0, cmd_cnt = 0, rd_cnt = 0, ferr_cnt = 0, crc_cnt = 0, busy_cnt = 0, multi_cnt = 0;
    int wr_cyc = 0, cmd_cyc = 0, rd_cyc = 0, ferr_cyc = 0;
    int rise_cyc = 0, cs_cyc = 0;

    spi_cmd_frame_slave #(
        .DATA_BYTES (2),
        .FB_BYTES   (4),
        .SYNC_STAGES(SYNC),
        .TIMEOUT_CYC(TO_CYC),
        .RD_OPCODE  (8'hAB)
    ) dut (
        .clk_in   (clk_in),
        .sys_rst  (sys_rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .fb_data  (fb_data),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cmd_valid(cmd_valid),
        .cmd_code (cmd_code),
        .rd_start (rd_start),
        .frame_err(frame_err),
        .crc_err  (crc_err),
        .busy     (busy)
    );

    always #10 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (wr_valid)  begin wr_cnt++;   wr_cyc   = cyc; end
        if (cmd_valid) begin cmd_cnt++;  cmd_cyc  = cyc; end
        if (rd_start)  begin rd_cnt++;   rd_cyc   = cyc; end
        if (frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
        if (crc_err)   crc_cnt++;
        if (busy)      busy_cnt++;
        if ($countones({wr_valid, cmd_valid, frame_err, crc_err}) > 1) multi_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "bench watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        wait_cyc(HALF);
        sclk = 1'b1;
        rise_cyc = cyc;
        r = miso;
        wait_cyc(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) spi_bit(tx[i], rx[i]);
    endtask

    task automatic frame_begin;
        cs_n = 1'b0;
        wait_cyc(HALF);
    endtask

    task automatic frame_end;
        wait_cyc(HALF + 8);
        cs_n = 1'b1;
        cs_cyc = cyc;
        wait_cyc(HALF + 8);
    endtask

`ifdef SPI_CRC8_EN
    // Bit-serial reference CRC-8, poly 0x07, init 0, MSB first.
    function automatic logic [7:0] crc_ref(input logic [23:0] msg);
        logic [7:0] c;
        logic       fbk;
        c = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fbk = c[7] ^ msg[i];
            c = {c[6:0], 1'b0} ^ (fbk ? 8'h07 : 8'h00);
        end
        return c;
    endfunction
`endif

    task automatic send_write(input logic [7:0] op, input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] rx;
        spi_byte(op, rx);
        spi_byte(d0, rx);
        spi_byte(d1, rx);
`ifdef SPI_CRC8_EN
        spi_byte(crc_ref({op, d0, d1}), rx);
`endif
    endtask

    initial begin
        int         wr0, cmd0, rd0, ferr0, busy0, crc0, waited, lat;
        logic [7:0] rx;
        logic       rb;

        sys_rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; fb_data = '0;
        wait_cyc(5);
        sys_rst = 1'b0;
        wait_cyc(2);
        check("rst_miso",      64'(miso), 0);
        check("rst_wr_valid",  64'(wr_valid), 0);
        check("rst_wr_addr",   64'(wr_addr), 0);
        check("rst_wr_data",   64'(wr_data), 0);
        check("rst_cmd_valid", 64'(cmd_valid), 0);
        check("rst_cmd_code",  64'(cmd_code), 0);
        check("rst_rd_start",  64'(rd_start), 0);
        check("rst_frame_err", 64'(frame_err), 0);
        check("rst_crc_err",   64'(crc_err), 0);
        check("rst_busy",      64'(busy), 0);

        wr0 = wr_cnt; ferr0 = ferr_cnt;
        frame_begin;
        send_write(8'h91, 8'h64, 8'h00);
        frame_end;
        check("w1_count",   64'(wr_cnt - wr0), 1);
        check("w1_addr",    64'(wr_addr), 17);
        check("w1_data",    64'(wr_data), 16'h0064);
        check("w1_latency", 64'(wr_cyc - rise_cyc), STB_LAT);
        check("w1_no_err",  64'(ferr_cnt - ferr0), 0);

        wr0 = wr_cnt;
        frame_begin;
        send_write(8'h9E, 8'h32, 8'h00);
        frame_end;
        check("w2_count", 64'(wr_cnt - wr0), 1);
        check("w2_addr",  64'(wr_addr), 30);
        check("w2_data",  64'(wr_data), 16'h0032);

        wr0 = wr_cnt; cmd0 = cmd_cnt; busy0 = busy_cnt;
        frame_begin;
        spi_byte(8'h06, rx);
        frame_end;
        check("cmd_count",   64'(cmd_cnt - cmd0), 1);
        check("cmd_code",    64'(cmd_code), 7'h06);
        check("cmd_no_wr",   64'(wr_cnt - wr0), 0);
        check("cmd_busy",    64'(busy_cnt - busy0), 0);
        check("cmd_latency", 64'(cmd_cyc - rise_cyc), STB_LAT);
        check("cmd_wr_held", 64'(wr_data), 16'h0032);

        fb_data = 32'h1234_5678;
        rd0 = rd_cnt; ferr0 = ferr_cnt;
        frame_begin;
        spi_byte(8'hAB, rx);
        check("rd_latency", 64'(rd_cyc - rise_cyc), STB_LAT);
        spi_byte(8'hFF, rx); check("rd_byte0", 64'(rx), 8'h12);
        spi_byte(8'hFF, rx); check("rd_byte1", 64'(rx), 8'h34);
        spi_byte(8'hFF, rx); check("rd_byte2", 64'(rx), 8'h56);
        spi_byte(8'hFF, rx); check("rd_byte3", 64'(rx), 8'h78);
        frame_end;
        check("rd_count",  64'(rd_cnt - rd0), 1);
        check("rd_miso0",  64'(miso), 0);
        check("rd_busy0",  64'(busy), 0);
        check("rd_no_err", 64'(ferr_cnt - ferr0), 0);

        wr0 = wr_cnt; ferr0 = ferr_cnt;
        frame_begin;
        spi_byte(8'h93, rx);
        spi_byte(8'h3C, rx);
        frame_end;
        check("abort_err",     64'(ferr_cnt - ferr0), 1);
        check("abort_no_wr",   64'(wr_cnt - wr0), 0);
        check("abort_latency", 64'(ferr_cyc - cs_cyc), STB_LAT);
        check("abort_held",    64'(wr_data), 16'h0032);
        wr0 = wr_cnt;
        frame_begin;
        send_write(8'h93, 8'h3C, 8'h00);
        frame_end;
        check("resume_count", 64'(wr_cnt - wr0), 1);
        check("resume_addr",  64'(wr_addr), 19);
        check("resume_data",  64'(wr_data), 16'h003C);

        wr0 = wr_cnt; ferr0 = ferr_cnt; cmd0 = cmd_cnt;
        frame_begin;
        spi_byte(8'h91, rx);
        spi_byte(8'h64, rx);
        waited = 0;
        while (ferr_cnt == ferr0 && waited < int'(TO_CYC) + 100) begin
            @(negedge clk_in);
            waited++;
        end
        wait_cyc(4);
        check("to_err",   64'(ferr_cnt - ferr0), 1);
        check("to_no_wr", 64'(wr_cnt - wr0), 0);
        lat = ferr_cyc - rise_cyc;
        tests++;
        assert (lat >= int'(TO_CYC) && lat <= int'(TO_CYC + SYNC + 3)) else begin
            fails++;
            $error("FAIL to_latency: observed %0d cycles expected %0d..%0d", lat, TO_CYC, TO_CYC + SYNC + 3);
        end
        check("to_busy0", 64'(busy), 0);
        spi_byte(8'h06, rx);
        frame_end;
        check("to_cmd_after", 64'(cmd_cnt - cmd0), 1);

        ferr0 = ferr_cnt; cmd0 = cmd_cnt;
        frame_begin;
        spi_byte(8'hC5, rx);
        frame_end;
        check("bad_op_err",    64'(ferr_cnt - ferr0), 1);
        check("bad_op_no_cmd", 64'(cmd_cnt - cmd0), 0);

        wr0 = wr_cnt; cmd0 = cmd_cnt; ferr0 = ferr_cnt; rd0 = rd_cnt; crc0 = crc_cnt;
        frame_begin;
        spi_byte(8'h91, rx);
        spi_bit(1'b0, rb); spi_bit(1'b1, rb); spi_bit(1'b1, rb); spi_bit(1'b0, rb);
        wait_cyc(HALF);
        sys_rst = 1'b1;
        wait_cyc(1);
        check("mid_rst_addr", 64'(wr_addr), 0);
        check("mid_rst_data", 64'(wr_data), 0);
        check("mid_rst_code", 64'(cmd_code), 0);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_miso", 64'(miso), 0);
        wait_cyc(2);
        sys_rst = 1'b0;
        wait_cyc(10);
        frame_end;
        check("mid_rst_strobes", 64'((wr_cnt - wr0) + (cmd_cnt - cmd0) + (ferr_cnt - ferr0) + (rd_cnt - rd0) + (crc_cnt - crc0)), 0);

`ifdef SPI_CRC8_EN
        wr0 = wr_cnt; crc0 = crc_cnt;
        frame_begin;
        send_write(8'h91, 8'h64, 8'h00);
        frame_end;
        check("crc_ok_wr",   64'(wr_cnt - wr0), 1);
        check("crc_ok_data", 64'(wr_data), 16'h0064);
        check("crc_ok_nerr", 64'(crc_cnt - crc0), 0);
        wr0 = wr_cnt; crc0 = crc_cnt;
        frame_begin;
        spi_byte(8'h9E, rx);
        spi_byte(8'h64, rx);
        spi_byte(8'h00, rx);
        spi_byte(crc_ref({8'h9E, 8'h64, 8'h00}) ^ 8'h01, rx);
        frame_end;
        check("crc_bad_err",  64'(crc_cnt - crc0), 1);
        check("crc_bad_nowr", 64'(wr_cnt - wr0), 0);
        check("crc_bad_addr", 64'(wr_addr), 17);
`else
        check("crc_never", 64'(crc_cnt), 0);
`endif
        check("one_strobe_per_cycle", 64'(multi_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
